// File: rtl/voice_scheduler.sv
// Voice allocator for the synthesizer channels: event FSM with oldest-voice stealing,
// plus a free-running slot sequencer that presents each channel's tuning word in turn.
module voice_scheduler #(
  parameter int NUM_BITS     = 32,
  parameter int NUM_CHANNELS = 16,
  parameter int KEY_BITS     = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [KEY_BITS-1:0]     ev_key,
  input  logic [NUM_BITS-1:0]     ev_tuning,
  output logic [NUM_CHANNELS-1:0] slot_strobe,
  output logic [NUM_BITS-1:0]     slot_tuning,
  output logic                    slot_active,
  output logic [NUM_CHANNELS-1:0] voices_busy,
  output logic                    full
);
  localparam int AW = $clog2(NUM_CHANNELS);
  localparam logic [AW-1:0] LAST = AW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

  state_t                  r_state;
  logic                    r_ev_ready;
  logic                    r_on;
  logic [KEY_BITS-1:0]     r_key;
  logic [NUM_BITS-1:0]     r_tun;
  logic [AW-1:0]           r_idx;
  logic                    r_has_match;
  logic                    r_has_free;
  logic [AW-1:0]           r_match;
  logic [AW-1:0]           r_free;
  logic [AW-1:0]           r_oldest;

  logic [NUM_CHANNELS-1:0] r_active;
  logic [KEY_BITS-1:0]     r_keys    [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     r_tunings [NUM_CHANNELS];
  logic [AW-1:0]           r_ages    [NUM_CHANNELS];

  logic [AW-1:0]           r_slot;
  logic [NUM_CHANNELS-1:0] r_slot_strobe;
  logic [NUM_BITS-1:0]     r_slot_tuning;
  logic                    r_slot_active;

  logic [AW-1:0]           w_target;
  logic [AW-1:0]           w_target_age;
  logic                    w_alloc_free;

  always_comb begin
    w_target     = r_has_match ? r_match : (r_has_free ? r_free : r_oldest);
    w_target_age = r_ages[w_target];
    w_alloc_free = !r_has_match && r_has_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ev_ready    <= 1'b0;
      r_on          <= 1'b0;
      r_key         <= '0;
      r_tun         <= '0;
      r_idx         <= '0;
      r_has_match   <= 1'b0;
      r_has_free    <= 1'b0;
      r_match       <= '0;
      r_free        <= '0;
      r_oldest      <= '0;
      r_active      <= '0;
      r_slot        <= '0;
      r_slot_strobe <= '0;
      r_slot_tuning <= '0;
      r_slot_active <= 1'b0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        r_keys[i]    <= '0;
        r_tunings[i] <= '0;
        r_ages[i]    <= '0;
      end
    end else begin
      r_slot        <= r_slot + 1'b1;
      r_slot_strobe <= NUM_CHANNELS'(1) << r_slot;
      r_slot_tuning <= r_active[r_slot] ? r_tunings[r_slot] : '0;
      r_slot_active <= r_active[r_slot];

      case (r_state)
        IDLE: begin
          r_ev_ready <= 1'b1;
          if (ev_valid && r_ev_ready) begin
            r_on        <= ev_on && (ev_tuning != '0);
            r_key       <= ev_key;
            r_tun       <= ev_tuning;
            r_idx       <= '0;
            r_has_match <= 1'b0;
            r_has_free  <= 1'b0;
            r_ev_ready  <= 1'b0;
            r_state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (r_active[r_idx]) begin
            if (!r_has_match && r_keys[r_idx] == r_key) begin
              r_has_match <= 1'b1;
              r_match     <= r_idx;
            end
            if (r_ages[r_idx] == LAST) r_oldest <= r_idx;
          end else if (!r_has_free) begin
            r_has_free <= 1'b1;
            r_free     <= r_idx;
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) r_state <= COMMIT;
        end
        COMMIT: begin
          // Age shuffle keeps active ages a dense, unique 0..n-1 ranking (0 = newest).
          for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (r_on) begin
              if (AW'(i) == w_target) begin
                r_active[i]  <= 1'b1;
                r_keys[i]    <= r_key;
                r_tunings[i] <= r_tun;
                r_ages[i]    <= '0;
              end else if (r_active[i] && (w_alloc_free || r_ages[i] < w_target_age)) begin
                r_ages[i] <= r_ages[i] + 1'b1;
              end
            end else if (r_has_match) begin
              if (AW'(i) == r_match) begin
                r_active[i]  <= 1'b0;
                r_tunings[i] <= '0;
                r_ages[i]    <= '0;
              end else if (r_active[i] && r_ages[i] > r_ages[r_match]) begin
                r_ages[i] <= r_ages[i] - 1'b1;
              end
            end
          end
          r_ev_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ev_ready    = r_ev_ready;
  assign slot_strobe = r_slot_strobe;
  assign slot_tuning = r_slot_tuning;
  assign slot_active = r_slot_active;
  assign voices_busy = r_active;
  assign full        = &r_active;
endmodule
